// File: rtl/pe_au_param.sv
// Parametrised multiply/accumulate unit for FIOS processing elements.
// Operand/product delay line feeds an ALU stage whose result is held in P.
module pe_au_param #(
  parameter int W     = 17,
  parameter int PW    = 48,
  parameter int ABREG = 1,
  parameter int MREG  = 1,
  parameter int CREG  = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ce_i,
  input  logic              valid_i,
  input  logic [2:0]        op_i,
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  input  logic              creg_en_i,
  input  logic [2*W-1:0]    c_i,
  input  logic [PW-1:0]     pcin_i,
  output logic [2*W-1:0]    p_o,
  output logic [PW-1:0]     pcout_o,
  output logic              valid_o
);

  if (ABREG < 0 || ABREG > 2 || MREG < 0 || MREG > 1 || CREG < 0 || CREG > 1
      || PW < 2*W + 2) begin : g_param_err
    $error("pe_au_param: illegal parameter combination");
  end

  logic [W-1:0]   a_s, b_s;
  logic [2:0]     op_s, op_m;
  logic           v_s, v_m;
  logic [2*W-1:0] m_prod, m_s, c_eff;
  logic [PW-1:0]  m_ext, c_ext, p_q, p_next;
  logic           valid_q;

  if (ABREG == 0) begin : g_ab_comb
    assign a_s  = a_i;
    assign b_s  = b_i;
    assign op_s = op_i;
    assign v_s  = valid_i;
  end else begin : g_ab_reg
    logic [W-1:0] a_q  [ABREG];
    logic [W-1:0] b_q  [ABREG];
    logic [2:0]   op_q [ABREG];
    logic         v_q  [ABREG];

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int unsigned i = 0; i < ABREG; i++) begin
          a_q[i]  <= '0;
          b_q[i]  <= '0;
          op_q[i] <= '0;
          v_q[i]  <= 1'b0;
        end
      end else if (ce_i) begin
        a_q[0]  <= a_i;
        b_q[0]  <= b_i;
        op_q[0] <= op_i;
        v_q[0]  <= valid_i;
        for (int unsigned i = 1; i < ABREG; i++) begin
          a_q[i]  <= a_q[i-1];
          b_q[i]  <= b_q[i-1];
          op_q[i] <= op_q[i-1];
          v_q[i]  <= v_q[i-1];
        end
      end
    end

    assign a_s  = a_q[ABREG-1];
    assign b_s  = b_q[ABREG-1];
    assign op_s = op_q[ABREG-1];
    assign v_s  = v_q[ABREG-1];
  end

  assign m_prod = {{W{1'b0}}, a_s} * {{W{1'b0}}, b_s};

  if (MREG == 0) begin : g_m_comb
    assign m_s  = m_prod;
    assign op_m = op_s;
    assign v_m  = v_s;
  end else begin : g_m_reg
    logic [2*W-1:0] m_q;
    logic [2:0]     op_q;
    logic           v_q;

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        m_q  <= '0;
        op_q <= '0;
        v_q  <= 1'b0;
      end else if (ce_i) begin
        m_q  <= m_prod;
        op_q <= op_s;
        v_q  <= v_s;
      end
    end

    assign m_s  = m_q;
    assign op_m = op_q;
    assign v_m  = v_q;
  end

  // C is not delayed with the op: the ALU always sees the current register value.
  if (CREG == 0) begin : g_c_comb
    logic unused_creg_en;
    assign unused_creg_en = creg_en_i;
    assign c_eff = c_i;
  end else begin : g_c_reg
    logic [2*W-1:0] c_q;

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        c_q <= '0;
      end else if (ce_i && creg_en_i) begin
        c_q <= c_i;
      end
    end

    assign c_eff = c_q;
  end

  assign m_ext = {{(PW-2*W){1'b0}}, m_s};
  assign c_ext = {{(PW-2*W){1'b0}}, c_eff};

  always_comb begin
    p_next = p_q;
    case (op_m)
      3'd0:    p_next = m_ext;
      3'd1:    p_next = m_ext + c_ext;
      3'd2:    p_next = m_ext + pcin_i;
      3'd3:    p_next = m_ext + (pcin_i >> W);
      3'd4:    p_next = m_ext + p_q;
      3'd5:    p_next = m_ext + (p_q >> W);
      3'd6:    p_next = c_ext + pcin_i;
      default: p_next = p_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      p_q     <= '0;
      valid_q <= 1'b0;
    end else if (ce_i) begin
      valid_q <= v_m;
      if (v_m) begin
        p_q <= p_next;
      end
    end
  end

  assign p_o     = p_q[2*W-1:0];
  assign pcout_o = p_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_pe_au_param.sv
// Directed checks of pe_au_param: default build (LAT=3) and a W=19 build
// with no operand/product/C registers (LAT=1).
module tb_pe_au_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  op = '0;
  logic [16:0] a = '0, b = '0;
  logic        creg_en = 1'b0;
  logic [33:0] c = '0;
  logic [47:0] pcin = '0;
  logic [33:0] p;
  logic [47:0] pcout;
  logic        vo;

  logic        v19 = 1'b0;
  logic [2:0]  op19 = '0;
  logic [18:0] a19 = '0, b19 = '0;
  logic        creg_en19 = 1'b0;
  logic [37:0] c19 = '0;
  logic [47:0] pcin19 = '0;
  logic [37:0] p19;
  logic [47:0] pcout19;
  logic        vo19;

  pe_au_param u_dut (
    .clock_i(clk), .reset_i(reset), .ce_i(ce), .valid_i(valid), .op_i(op),
    .a_i(a), .b_i(b), .creg_en_i(creg_en), .c_i(c), .pcin_i(pcin),
    .p_o(p), .pcout_o(pcout), .valid_o(vo)
  );

  pe_au_param #(.W(19), .PW(48), .ABREG(0), .MREG(0), .CREG(0)) u_dut19 (
    .clock_i(clk), .reset_i(reset), .ce_i(ce), .valid_i(v19), .op_i(op19),
    .a_i(a19), .b_i(b19), .creg_en_i(creg_en19), .c_i(c19), .pcin_i(pcin19),
    .p_o(p19), .pcout_o(pcout19), .valid_o(vo19)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one valid op for one edge, then wait until its result is on P.
  task automatic run_op(input logic [2:0] o, input logic [16:0] x, input logic [16:0] y);
    op = o; a = x; b = y; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_p", 64'(p), 64'h0);
    check("rst_pcout", 64'(pcout), 64'h0);
    check("rst_valid", 64'(vo), 64'h0);
    check("rst_valid19", 64'(vo19), 64'h0);

    // Latency with maximum product
    op = 3'd0; a = 17'h1FFFF; b = 17'h1FFFF; valid = 1'b1;
    step();
    valid = 1'b0;
    check("lat_e0_valid", 64'(vo), 64'h0);
    step();
    check("lat_e1_valid", 64'(vo), 64'h0);
    step();
    check("lat_e2_valid", 64'(vo), 64'h1);
    check("lat_e2_p", 64'(p), 64'h3FFFC0001);
    step();
    check("lat_e3_valid", 64'(vo), 64'h0);
    check("lat_e3_p", 64'(p), 64'h3FFFC0001);

    // C register load then hold
    c = 34'h12345; creg_en = 1'b1;
    step();
    creg_en = 1'b0; c = '0;
    run_op(3'd1, 17'd2, 17'd3);
    check("creg_p", 64'(p), 64'h1234B);

    // Cascade input
    pcin = 48'h60000;
    run_op(3'd3, 17'd2, 17'd5);
    check("casc_shift_p", 64'(p), 64'd13);
    run_op(3'd2, 17'd2, 17'd5);
    check("casc_p", 64'(p), 64'h6000A);

    // Back-to-back accumulate-shift
    op = 3'd0; a = 17'd4; b = 17'h10000; valid = 1'b1;
    step();
    op = 3'd5; a = 17'd1; b = 17'd1;
    step();
    valid = 1'b0;
    step();
    check("accsh_first_p", 64'(p), 64'h40000);
    check("accsh_first_valid", 64'(vo), 64'h1);
    step();
    check("accsh_second_p", 64'(p), 64'd3);
    check("accsh_second_valid", 64'(vo), 64'h1);
    run_op(3'd4, 17'd2, 17'd5);
    check("acc_p", 64'(p), 64'd13);

    // Stall with a freshly written result and a new op waiting at the input
    run_op(3'd0, 17'd3, 17'd7);
    check("pre_stall_p", 64'(p), 64'd21);
    ce = 1'b0;
    op = 3'd0; a = 17'd2; b = 17'd2; valid = 1'b1;
    repeat (4) step();
    check("stall_valid", 64'(vo), 64'h1);
    check("stall_p", 64'(p), 64'd21);
    ce = 1'b1;
    step();
    valid = 1'b0;
    check("unstall_e0_valid", 64'(vo), 64'h0);
    check("unstall_e0_p", 64'(p), 64'd21);
    step();
    step();
    check("unstall_e2_valid", 64'(vo), 64'h1);
    check("unstall_e2_p", 64'(p), 64'd4);

    // Bubble and hold opcode
    op = 3'd0; a = 17'd5; b = 17'd5; valid = 1'b0;
    repeat (3) step();
    check("bubble_p", 64'(p), 64'd4);
    check("bubble_valid", 64'(vo), 64'h0);
    run_op(3'd7, 17'd1, 17'd1);
    check("hold_op_p", 64'(p), 64'd4);
    check("hold_op_valid", 64'(vo), 64'h1);

    // Wrap modulo 2^48
    c = 34'h3_FFFF_FFFF; creg_en = 1'b1;
    step();
    creg_en = 1'b0;
    pcin = 48'hFFFF_FFFF_FFFF;
    run_op(3'd6, 17'd0, 17'd0);
    check("wrap_pcout", 64'(pcout), 64'h3_FFFF_FFFE);

    // W=19, LAT=1, combinational C
    op19 = 3'd0; a19 = 19'd1; b19 = 19'h40000; v19 = 1'b1;
    step();
    check("w19_first_p", 64'(p19), 64'h40000);
    check("w19_first_valid", 64'(vo19), 64'h1);
    op19 = 3'd5; a19 = 19'd1; b19 = 19'd1;
    step();
    check("w19_accsh_p", 64'(p19), 64'd1);
    v19 = 1'b0;
    step();
    check("w19_bubble_valid", 64'(vo19), 64'h0);
    check("w19_bubble_p", 64'(p19), 64'd1);
    op19 = 3'd6; c19 = 38'd5; pcin19 = 48'd7; v19 = 1'b1;
    step();
    check("w19_cpcin_p", 64'(p19), 64'd12);
    op19 = 3'd1; a19 = 19'd3; b19 = 19'd3; c19 = 38'd10;
    step();
    check("w19_mc_p", 64'(p19), 64'd19);
    v19 = 1'b0;

    // Reset with two ops in flight
    op = 3'd0; a = 17'd9; b = 17'd9; valid = 1'b1;
    step();
    a = 17'd8; b = 17'd8;
    step();
    valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_p", 64'(p), 64'h0);
    check("midrst_pcout", 64'(pcout), 64'h0);
    check("midrst_valid", 64'(vo), 64'h0);
    check("midrst_p19", 64'(p19), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("postrst_valid", 64'(vo), 64'h0);
      check("postrst_p", 64'(p), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_au_param.md
Name: pe_au_param

Overview:
- Parametrised, vendor-neutral behavioural arithmetic unit for FIOS processing elements.
- Successor to the fixed 17x17 DSP-primitive PE arithmetic unit: word width, pipeline depth and opcode set are generic.
- Adds valid tracking, a global stall and self-feedback modes (accumulate, accumulate with word shift).
- Sits inside each PE. Chains to neighbouring PEs through pcin_i/pcout_o.

Parameters:
- W, 17: operand word width in bits; product is 2W bits.
- PW, 48: accumulator/P/cascade width; must satisfy PW >= 2W+2.
- ABREG, 1: operand register stages, 0..2.
- MREG, 1: product register stages, 0..1.
- CREG, 1: C register stage, 0..1.
- LAT (local), 1+ABREG+MREG: input-to-output latency in enabled cycles.

Ports:
- clock_i, in, 1: clock; all state updates on rising edge.
- reset_i, in, 1: synchronous active-high reset.
- ce_i, in, 1: global clock enable; 0 freezes every pipeline stage, P and the C register.
- valid_i, in, 1: marks the current A/B/op as a real operation.
- op_i, in, 3: operation code, travels with A/B (see Behaviour).
- a_i, in, W: unsigned multiplicand.
- b_i, in, W: unsigned multiplier.
- creg_en_i, in, 1: C register load enable.
- c_i, in, 2W: unsigned addend.
- pcin_i, in, PW: cascade input from the upstream PE.
- p_o, out, 2W: P[2W-1:0].
- pcout_o, out, PW: full P register.
- valid_o, out, 1: P holds the result of a valid operation.

Behaviour:
- Reset (dominates ce_i):
  - Clears all A/B/product pipeline registers, op and valid delay lines, the C register and P.
  - Outputs on the cycle after reset is asserted: p_o=0, pcout_o=0, valid_o=0.
  - Reset mid-operation discards every in-flight operation; no partial result ever appears.
- Pipeline:
  - a_i, b_i, op_i and valid_i enter a delay line of ABREG+MREG stages that advances only when ce_i=1.
  - The ALU stage computes in that same cycle, and P registers its result.
  - An operation presented at enabled edge k appears on P/p_o/valid_o after enabled edge k+LAT-1.
  - Default LAT=3: sampled at edge 0, visible after edge 2.
  - ABREG=MREG=0 gives a single P register, LAT=1.
- Product: M = a*b, unsigned, exactly 2W bits, zero-extended to PW.
- C path:
  - CREG=1: the C register loads c_i when ce_i && creg_en_i, else holds. The ALU uses the register content of the current cycle, not delayed with the op.
  - CREG=0: the ALU uses c_i combinationally. creg_en_i is ignored.
- ALU opcodes (at ALU stage; all sums modulo 2^PW; shifts logical):
  - 0: P <= M
  - 1: P <= M + C
  - 2: P <= M + pcin_i
  - 3: P <= M + (pcin_i >> W)
  - 4: P <= M + P
  - 5: P <= M + (P >> W)
  - 6: P <= C + pcin_i
  - 7: P <= P (hold, no write)
- pcin_i is sampled combinationally at the ALU stage, in the cycle the op reaches it.
- Invalid ops:
  - P updates only when the op at the ALU stage is valid and ce_i=1.
  - A bubble leaves P unchanged and drives valid_o low for that cycle.
- valid_o:
  - Registered with P; high exactly one enabled cycle per valid op.
  - With ce_i=0, valid_o and P hold their previous values.
- Back-to-back: one operation accepted per enabled cycle, with no bubbles required. Opcodes 4/5 use the P value written by the immediately preceding valid op.
- Parameter checks: out-of-range ABREG/MREG/CREG or PW < 2W+2 must produce an elaboration error.

Test Plan:
- Latency/max product (defaults): a=0x1FFFF, b=0x1FFFF, op=0, valid pulse at edge 0. Expect p_o=0x3FFFC0001 and valid_o=1 after edge 2 only.
- C register: c_i=0x12345 with creg_en_i=1 for one cycle, then c_i=0x0 with creg_en_i=0. Then op=1, a=2, b=3. Expect p_o=0x1234B.
- Cascade shift: pcin_i=0x60000, op=3, a=2, b=5. Expect p_o=13. Same inputs with op=2. Expect p_o=0x6000A.
- Accumulate-shift chain, back-to-back:
  - op0 a=1, b=0x40000 (W=19 build), followed by op5 a=1, b=1.
  - Expect first P=0x40000, then P=0x40000>>19 + 1 = 1.
  - Repeat at W=17 with a first product of 0x40000; expect the second P=3.
- Stall/bubble/reset:
  - ce_i=0 for 4 cycles mid-flight: valid_o and P frozen; result appears LAT enabled cycles after issue.
  - valid_i=0 op: P unchanged, valid_o=0.
  - reset_i pulsed with 2 ops in flight: no valid_o afterwards, and P=0.
- Wrap: PW=48, op=6, C=0x3_FFFF_FFFF (W=17), pcin_i=0xFFFF_FFFF_FFFF. Expect pcout_o=0x3_FFFF_FFFE, i.e. the sum modulo 2^48.
